// File: rtl/antic_dma_scheduler.sv
// ANTIC DMA scheduler: arbitrates the shared bus among display-list, playfield,
// character, player-missile and refresh fetches, runs the two-cycle ADDR/DATA
// bus sequence, and generates the WSYNC CPU hold.
//
// Handshake: a requester raises req_x with addr_x and holds both until its ack
// bit pulses for one cycle. Dropping req_x before it is granted withdraws it.
// A grant always completes, even if req_x drops afterwards. Arbitration runs in
// IDLE and again in the DATA cycle, and it looks at every request that is high
// at that moment. A requester that still has req_x high during its own ack
// cycle is therefore taken as making a new request.
module antic_dma_scheduler #(
    parameter int REF_MAX = 8
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [7:0]  dmactl,
    input  logic        req_dl,
    input  logic [15:0] addr_dl,
    input  logic        req_pf,
    input  logic [15:0] addr_pf,
    input  logic        req_ch,
    input  logic [15:0] addr_ch,
    input  logic        req_pm,
    input  logic [15:0] addr_pm,
    input  logic        req_rf,
    input  logic [7:0]  db_in,
    input  logic        wsync_wr,
    input  logic        hsync,
    output logic [15:0] address,
    output logic [7:0]  dma_data,
    output logic [4:0]  grant,
    output logic [4:0]  ack,
    output logic        halt_L,
    output logic        REF_L,
    output logic        RDY_L
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    localparam logic [7:0] REF_LIMIT = 8'(REF_MAX);

    state_t      state_q, state_d;
    logic        load;
    logic [4:0]  eff;
    logic [4:0]  win;
    logic [15:0] win_addr;
    logic [7:0]  ref_wait;
    logic [7:0]  ref_ctr;
    logic        unused_dmactl;

    assign unused_dmactl = ^{dmactl[7:6], dmactl[4]};

    // Gate the raw requests with DMACTL; refresh is never gated.
    always_comb begin
        eff    = 5'b0;
        eff[0] = req_dl & dmactl[5];
        eff[1] = req_pf & (|dmactl[1:0]);
        eff[2] = req_ch & (|dmactl[1:0]);
        eff[3] = req_pm & (|dmactl[3:2]);
        eff[4] = req_rf;
    end

    // Fixed priority PM > DL > PF > CH > RF, with starved refresh promoted to the top.
    always_comb begin
        win      = 5'b0;
        win_addr = 16'h0000;
        if (eff[4] && (ref_wait == REF_LIMIT)) begin
            win      = 5'b10000;
            win_addr = {8'h00, ref_ctr};
        end else if (eff[3]) begin
            win      = 5'b01000;
            win_addr = addr_pm;
        end else if (eff[0]) begin
            win      = 5'b00001;
            win_addr = addr_dl;
        end else if (eff[1]) begin
            win      = 5'b00010;
            win_addr = addr_pf;
        end else if (eff[2]) begin
            win      = 5'b00100;
            win_addr = addr_ch;
        end else if (eff[4]) begin
            win      = 5'b10000;
            win_addr = {8'h00, ref_ctr};
        end
    end

    // Next-state logic; load marks a cycle that starts a new ADDR phase.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|win) begin
                    state_d = S_ADDR;
                    load    = 1'b1;
                end
            end
            S_ADDR: state_d = S_DATA;
            S_DATA: begin
                if (|win) begin
                    state_d = S_ADDR;
                    load    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Bus outputs: latch the winner on entry to ADDR, capture data and ack at the end of ADDR.
    always_ff @(posedge clk) begin
        if (RST) begin
            address  <= 16'h0000;
            dma_data <= 8'h00;
            grant    <= 5'b0;
            ack      <= 5'b0;
            halt_L   <= 1'b1;
            REF_L    <= 1'b1;
            ref_ctr  <= 8'h00;
        end else begin
            ack <= 5'b0;
            if (load) begin
                grant   <= win;
                address <= win_addr;
                halt_L  <= 1'b0;
                REF_L   <= ~win[4];
            end else if (state_q == S_ADDR) begin
                dma_data <= db_in;
                ack      <= grant;
                REF_L    <= 1'b1;
                if (grant[4]) ref_ctr <= ref_ctr + 8'h01;
            end else if (state_q == S_DATA) begin
                grant  <= 5'b0;
                halt_L <= 1'b1;
                REF_L  <= 1'b1;
            end
        end
    end

    // Count how long a pending refresh has been kept off the bus.
    always_ff @(posedge clk) begin
        if (RST) begin
            ref_wait <= 8'h00;
        end else if (load && win[4]) begin
            ref_wait <= 8'h00;
        end else if (req_rf && !grant[4] && (ref_wait != REF_LIMIT)) begin
            ref_wait <= ref_wait + 8'h01;
        end
    end

    // WSYNC hold: set by a WSYNC write, released after a cycle that sees hsync.
    always_ff @(posedge clk) begin
        if (RST)           RDY_L <= 1'b1;
        else if (wsync_wr) RDY_L <= 1'b0;
        else if (hsync)    RDY_L <= 1'b1;
    end

endmodule

// File: tb/tb_antic_dma_scheduler.sv
// Directed bench for antic_dma_scheduler with a scoreboard of expected ADDR and
// DATA cycles.
module tb_antic_dma_scheduler;

    logic        clk = 1'b0;
    logic        RST;
    logic [7:0]  dmactl;
    logic        req_dl, req_pf, req_ch, req_pm, req_rf;
    logic [15:0] addr_dl, addr_pf, addr_ch, addr_pm;
    logic [7:0]  db_in;
    logic        wsync_wr, hsync;
    logic [15:0] address;
    logic [7:0]  dma_data;
    logic [4:0]  grant, ack;
    logic        halt_L, REF_L, RDY_L;

    int errors = 0;
    int checks = 0;

    // {grant, REF_L, address} expected in each ADDR cycle
    logic [21:0] adr_q[$];
    // {ack, dma_data} expected in each DATA cycle
    logic [12:0] exp_q[$];
    logic [7:0]  exp_ref_ctr = 8'h00;

    localparam logic [4:0] G_DL = 5'b00001;
    localparam logic [4:0] G_PF = 5'b00010;
    localparam logic [4:0] G_CH = 5'b00100;
    localparam logic [4:0] G_PM = 5'b01000;
    localparam logic [4:0] G_RF = 5'b10000;

    antic_dma_scheduler #(.REF_MAX(4)) dut (
        .clk(clk), .RST(RST), .dmactl(dmactl),
        .req_dl(req_dl), .addr_dl(addr_dl),
        .req_pf(req_pf), .addr_pf(addr_pf),
        .req_ch(req_ch), .addr_ch(addr_ch),
        .req_pm(req_pm), .addr_pm(addr_pm),
        .req_rf(req_rf), .db_in(db_in),
        .wsync_wr(wsync_wr), .hsync(hsync),
        .address(address), .dma_data(dma_data),
        .grant(grant), .ack(ack),
        .halt_L(halt_L), .REF_L(REF_L), .RDY_L(RDY_L)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_txn(input logic [4:0] g, input logic [15:0] a, input logic [7:0] d);
        adr_q.push_back({g, ~g[4], a});
        exp_q.push_back({g, d});
    endtask

    task automatic push_rf(input logic [7:0] d);
        push_txn(G_RF, {8'h00, exp_ref_ctr}, d);
        exp_ref_ctr = exp_ref_ctr + 8'h01;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_address"}, address, 16'h0000);
        check({tag, "_dma_data"}, dma_data, 8'h00);
        check({tag, "_grant"}, grant, 5'b0);
        check({tag, "_ack"}, ack, 5'b0);
        check({tag, "_halt_L"}, halt_L, 1'b1);
        check({tag, "_REF_L"}, REF_L, 1'b1);
        check({tag, "_RDY_L"}, RDY_L, 1'b1);
    endtask

    // Scoreboard: compare every ADDR and DATA cycle against the queued expectations.
    always @(negedge clk) begin
        logic [21:0] ea;
        logic [12:0] ed;
        if (grant != 5'b0 && ack == 5'b0) begin
            if (adr_q.size() == 0) begin
                check("unexpected_grant", grant, 5'b0);
            end else begin
                ea = adr_q.pop_front();
                check("sb_grant", grant, ea[21:17]);
                check("sb_REF_L", REF_L, ea[16]);
                check("sb_address", address, ea[15:0]);
                check("sb_halt_L_addr", halt_L, 1'b0);
            end
        end
        if (ack != 5'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", ack, 5'b0);
            end else begin
                ed = exp_q.pop_front();
                check("sb_ack", ack, ed[12:8]);
                check("sb_dma_data", dma_data, ed[7:0]);
                check("sb_halt_L_data", halt_L, 1'b0);
            end
        end
    end

    // Drop each request on its ack; finish when the bus is idle and the watched requests are low.
    task automatic serve(input int budget, input logic [4:0] watch, output int best_run);
        int  cur;
        bit  done;
        cur = 0;
        best_run = 0;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            if (!halt_L) cur++;
            else cur = 0;
            if (cur > best_run) best_run = cur;
            if (ack[0]) req_dl = 1'b0;
            if (ack[1]) req_pf = 1'b0;
            if (ack[2]) req_ch = 1'b0;
            if (ack[3]) req_pm = 1'b0;
            if (ack[4]) req_rf = 1'b0;
            if (halt_L && (({req_rf, req_pm, req_ch, req_pf, req_dl} & watch) == 5'b0))
                done = 1'b1;
        end
        check("serve_timeout", done, 1'b1);
    endtask

    initial begin
        int run;
        int seen;
        RST = 1'b1; dmactl = 8'h00;
        req_dl = 0; req_pf = 0; req_ch = 0; req_pm = 0; req_rf = 0;
        addr_dl = 16'h0; addr_pf = 16'h0; addr_ch = 16'h0; addr_pm = 16'h0;
        db_in = 8'h00; wsync_wr = 0; hsync = 0;

        // Power-on reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        RST = 1'b0;

        // Reset in the middle of a DL transaction: ADDR happens, no ack follows
        dmactl = 8'h20; req_dl = 1'b1; addr_dl = 16'h1234; db_in = 8'h77;
        adr_q.push_back({G_DL, 1'b1, 16'h1234});
        @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst1");
        @(negedge clk);
        check_reset_outputs("midrst2");
        req_dl = 1'b0; RST = 1'b0;
        @(negedge clk);
        check("midrst_no_ack", ack, 5'b0);
        check("midrst_idle_halt", halt_L, 1'b1);

        // Single DL fetch with cycle-exact latency
        dmactl = 8'h20; req_dl = 1'b1; addr_dl = 16'h3000; db_in = 8'hA5;
        push_txn(G_DL, 16'h3000, 8'hA5);
        @(negedge clk);
        check("dl_c1_address", address, 16'h3000);
        check("dl_c1_halt_L", halt_L, 1'b0);
        check("dl_c1_grant", grant, G_DL);
        @(negedge clk);
        check("dl_c2_ack", ack, G_DL);
        check("dl_c2_data", dma_data, 8'hA5);
        req_dl = 1'b0;
        @(negedge clk);
        check("dl_c3_halt_L", halt_L, 1'b1);
        check("dl_c3_grant", grant, 5'b0);
        check("dl_c3_ack", ack, 5'b0);
        check("dl_idle_address_hold", address, 16'h3000);

        // PM, DL and PF together: priority order, back-to-back bus ownership
        dmactl = 8'h2D; db_in = 8'h5C;
        addr_pm = 16'h8800; addr_dl = 16'h3100; addr_pf = 16'h4000;
        req_pm = 1'b1; req_dl = 1'b1; req_pf = 1'b1;
        push_txn(G_PM, 16'h8800, 8'h5C);
        push_txn(G_DL, 16'h3100, 8'h5C);
        push_txn(G_PF, 16'h4000, 8'h5C);
        serve(40, 5'b11111, run);
        check("trio_halt_run", run, 6);

        // DL, PF and CH together with PM disabled
        dmactl = 8'h22; db_in = 8'hC3;
        addr_dl = 16'h3200; addr_pf = 16'h4100; addr_ch = 16'hE000;
        req_dl = 1'b1; req_pf = 1'b1; req_ch = 1'b1; req_pm = 1'b1;
        push_txn(G_DL, 16'h3200, 8'hC3);
        push_txn(G_PF, 16'h4100, 8'hC3);
        push_txn(G_CH, 16'hE000, 8'hC3);
        serve(40, 5'b00111, run);
        check("dpc_halt_run", run, 6);
        req_pm = 1'b0;

        // Everything disabled by DMACTL: no bus activity until refresh asks
        dmactl = 8'h00; db_in = 8'h3E;
        req_dl = 1'b1; req_pf = 1'b1; req_pm = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("gated_grant", grant, 5'b0);
            check("gated_halt_L", halt_L, 1'b1);
        end
        req_rf = 1'b1;
        push_rf(8'h3E);
        serve(20, 5'b10000, run);
        check("rf_halt_run", run, 2);
        req_dl = 1'b0; req_pf = 1'b0; req_pm = 1'b0;

        // Starved refresh: PF and RF held, RF promoted once ref_wait reaches REF_MAX
        dmactl = 8'h01; db_in = 8'h69; addr_pf = 16'h4200;
        req_pf = 1'b1; req_rf = 1'b1;
        push_txn(G_PF, 16'h4200, 8'h69);
        push_txn(G_PF, 16'h4200, 8'h69);
        push_rf(8'h69);
        push_txn(G_PF, 16'h4200, 8'h69);
        seen = 0;
        for (int n = 0; n < 30 && seen < 4; n++) begin
            @(negedge clk);
            if (grant != 5'b0 && ack == 5'b0) seen++;
        end
        check("starve_addr_cycles", seen, 4);
        req_pf = 1'b0; req_rf = 1'b0;
        serve(20, 5'b11111, run);

        // Refresh counter advanced on each refresh ack
        dmactl = 8'h00; db_in = 8'h12; req_rf = 1'b1;
        push_rf(8'h12);
        serve(20, 5'b10000, run);

        // WSYNC hold released the cycle after hsync
        @(negedge clk);
        wsync_wr = 1'b1;
        @(negedge clk);
        wsync_wr = 1'b0;
        check("wsync_c1", RDY_L, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            check("wsync_hold", RDY_L, 1'b0);
        end
        hsync = 1'b1;
        @(negedge clk);
        hsync = 1'b0;
        check("wsync_release", RDY_L, 1'b1);

        // WSYNC coincident with hsync keeps holding until the next hsync
        @(negedge clk);
        wsync_wr = 1'b1; hsync = 1'b1;
        @(negedge clk);
        wsync_wr = 1'b0; hsync = 1'b0;
        check("wsync_coinc_c1", RDY_L, 1'b0);
        @(negedge clk);
        check("wsync_coinc_c2", RDY_L, 1'b0);
        hsync = 1'b1;
        @(negedge clk);
        hsync = 1'b0;
        check("wsync_coinc_release", RDY_L, 1'b1);

        repeat (2) @(negedge clk);
        check("adr_q_empty", adr_q.size(), 0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
